core_launch_sequencer: RTL and testbench

- Hardware initiator for the RISC_V_Core control interface (reset/start/prog_address/report).
- On a launch request it sequences the core:
  - holds core reset for a programmable time;
  - pulses start with the program address;
  - counts run cycles until the core signals halt or a timeout expires;
  - pulses report and presents the cycle count.
- Sits between the SoC host/debug port and the core, replacing bench-driven start sequencing.

---
 rtl/core_ctrl_pkg.sv | 6 +
 rtl/launch_phase_counter.sv | 17 +
 rtl/core_launch_sequencer.sv | 99 +++++++++
 tb/tb_core_launch_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared sequencer state encoding and default phase lengths.
package core_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RESET_HOLD, START, RUN, REPORT, DONE} state_t;
  localparam int DEFAULT_RESET_CYCLES = 2;
  localparam int DEFAULT_START_CYCLES = 1;
endpackage

// File: rtl/launch_phase_counter.sv
// launch_phase_counter: loadable down-counter with zero flag for phase durations.
module launch_phase_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clock)
    if (!reset) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - 1'b1;
  assign zero = count == '0;
endmodule

// File: rtl/core_launch_sequencer.sv
// core_launch_sequencer: sequences core reset/start/run/report around a launch request.
module core_launch_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int ADDRESS_BITS = 20,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int START_CYCLES = DEFAULT_START_CYCLES,
  parameter int COUNT_WIDTH = 32,
  parameter logic [COUNT_WIDTH-1:0] TIMEOUT_DEFAULT = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    launch,
  input  logic [ADDRESS_BITS-1:0] launch_address,
  input  logic [COUNT_WIDTH-1:0]  timeout_limit,
  input  logic                    abort,
  input  logic                    core_halted,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [ADDRESS_BITS-1:0] core_prog_address,
  output logic                    core_report,
  output logic                    busy,
  output logic                    done,
  output logic                    timed_out,
  output logic                    aborted,
  output logic [COUNT_WIDTH-1:0]  cycle_count
);
  localparam int PW = $clog2((RESET_CYCLES > START_CYCLES ? RESET_CYCLES : START_CYCLES) + 1);
  state_t state, next;
  logic [ADDRESS_BITS-1:0] address;
  logic [COUNT_WIDTH-1:0] limit, inc;
  logic [PW-1:0] load_value;
  logic load, phase_zero, accept, abort_early, run_timeout;
  logic reset_d, start_d, report_d, busy_d, done_d;
  launch_phase_counter #(.WIDTH(PW)) phase (
    .clock(clock), .reset(reset), .load(load), .value(load_value), .zero(phase_zero)
  );
  assign accept = launch && (state == IDLE || state == DONE);
  assign abort_early = abort && (state == RESET_HOLD || state == START);
  assign inc = &cycle_count ? cycle_count : cycle_count + 1'b1;
  assign run_timeout = limit != '0 && inc == limit;
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      core_reset <= 1'b1;
      core_start <= 1'b0;
      core_report <= 1'b0;
      core_prog_address <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      timed_out <= 1'b0;
      aborted <= 1'b0;
      cycle_count <= '0;
      address <= '0;
      limit <= TIMEOUT_DEFAULT;
    end else begin
      state <= next;
      core_reset <= reset_d;
      core_start <= start_d;
      core_report <= report_d;
      busy <= busy_d;
      done <= done_d;
      if (accept) begin
        address <= launch_address;
        limit <= timeout_limit;
        cycle_count <= '0;
        timed_out <= 1'b0;
        aborted <= 1'b0;
      end
      if (next == START) core_prog_address <= address;
      // Exit priority abort > halt > timeout resolves which flag the exit cycle sets.
      if (state == RUN) begin
        cycle_count <= inc;
        aborted <= abort;
        timed_out <= !abort && !core_halted && run_timeout;
      end
      if (abort_early) aborted <= 1'b1;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = launch ? RESET_HOLD : state;
      RESET_HOLD: next = abort ? IDLE : phase_zero ? START : RESET_HOLD;
      START:      next = abort ? IDLE : phase_zero ? RUN : START;
      RUN:        next = (abort || core_halted || run_timeout) ? REPORT : RUN;
      REPORT:     next = DONE;
      default:    next = IDLE;
    endcase
  end
  always_comb begin
    load = (next == RESET_HOLD && state != RESET_HOLD) || (next == START && state != START);
    load_value = next == RESET_HOLD ? PW'(RESET_CYCLES - 1) : PW'(START_CYCLES - 1);
    reset_d = next == IDLE || next == RESET_HOLD;
    start_d = next == START;
    report_d = next == REPORT;
    busy_d = next == RESET_HOLD || next == START || next == RUN || next == REPORT;
    done_d = next == DONE;
  end
endmodule

// File: tb/tb_core_launch_sequencer.sv
// tb_core_launch_sequencer: randomized and directed checks of two sequencer configurations.
module tb_core_launch_sequencer;
  logic clock = 0, reset = 0, launch = 0, abort = 0, core_halted = 0;
  logic [19:0] launch_address = '0;
  logic [31:0] timeout_limit = '0;
  logic r0, s0, p0, b0, d0, t0, ab0, r1, s1, p1, b1, d1, t1, ab1;
  logic [19:0] a0, a1, adr;
  logic [31:0] c0, c1, cnt;
  logic [4:0] ctl;
  logic [1:0] fl;
  int total = 0, bad = 0, sel = 0;

  core_launch_sequencer dut0 (
    .clock(clock), .reset(reset), .launch(launch), .launch_address(launch_address),
    .timeout_limit(timeout_limit), .abort(abort), .core_halted(core_halted),
    .core_reset(r0), .core_start(s0), .core_prog_address(a0), .core_report(p0),
    .busy(b0), .done(d0), .timed_out(t0), .aborted(ab0), .cycle_count(c0)
  );
  core_launch_sequencer #(.RESET_CYCLES(4), .START_CYCLES(3)) dut1 (
    .clock(clock), .reset(reset), .launch(launch), .launch_address(launch_address),
    .timeout_limit(timeout_limit), .abort(abort), .core_halted(core_halted),
    .core_reset(r1), .core_start(s1), .core_prog_address(a1), .core_report(p1),
    .busy(b1), .done(d1), .timed_out(t1), .aborted(ab1), .cycle_count(c1)
  );

  always #5 clock = ~clock;

  // ctl = {busy, core_reset, core_start, core_report, done}; fl = {timed_out, aborted}
  always_comb begin
    ctl = sel != 0 ? {b1, r1, s1, p1, d1} : {b0, r0, s0, p0, d0};
    fl = sel != 0 ? {t1, ab1} : {t0, ab0};
    cnt = sel != 0 ? c1 : c0;
    adr = sel != 0 ? a1 : a0;
  end

  task automatic do_reset;
    @(negedge clock);
    reset = 0; launch = 0; abort = 0; core_halted = 0;
    @(negedge clock);
    reset = 1;
  endtask

  // Expected exit cycle is the earliest of abort, halt and limit; flags follow abort > halt > timeout.
  task automatic launch_run(input int d, input logic [19:0] addr, input logic [31:0] lim,
                            input int halt_at, input int abort_at);
    int r, s, k;
    logic ab, to;
    sel = d;
    r = d != 0 ? 4 : 2;
    s = d != 0 ? 3 : 1;
    k = 1 << 30;
    if (abort_at > 0 && abort_at < k) k = abort_at;
    if (halt_at > 0 && halt_at < k) k = halt_at;
    if (lim != 0 && int'(lim) < k) k = int'(lim);
    ab = abort_at == k;
    to = !ab && halt_at != k && int'(lim) == k;
    @(negedge clock);
    launch = 1; launch_address = addr; timeout_limit = lim;
    for (int i = 1; i <= r + s; i++) begin
      @(negedge clock);
      total++;
      if ({ctl, fl, cnt} !== {1'b1, i <= r, i > r, 2'b00, 2'b00, 32'd0}) begin
        bad++;
        $display("FAIL phase%0d d%0d got=%b/%b/%0d exp=%b/00/0", i, d, ctl, fl, cnt, {1'b1, i <= r, i > r, 2'b00});
      end
      if (i > r) begin
        total++;
        if (adr !== addr) begin
          bad++;
          $display("FAIL start_addr d%0d got=%h exp=%h", d, adr, addr);
        end
      end
      launch = i == 1;
      launch_address = ~addr;
    end
    for (int j = 1; j <= k; j++) begin
      @(negedge clock);
      total++;
      if ({ctl, cnt} !== {5'b10000, 32'(j - 1)}) begin
        bad++;
        $display("FAIL run%0d d%0d got=%b/%0d exp=10000/%0d", j, d, ctl, cnt, j - 1);
      end
      core_halted = halt_at != 0 && j >= halt_at;
      abort = abort_at == j;
      launch = j == 1;
    end
    @(negedge clock);
    core_halted = 0; abort = 0; launch = 0;
    total++;
    if ({ctl, fl, cnt} !== {5'b10010, to, ab, 32'(k)}) begin
      bad++;
      $display("FAIL report d%0d got=%b/%b/%0d exp=10010/%b%b/%0d", d, ctl, fl, cnt, to, ab, k);
    end
    @(negedge clock);
    total++;
    if ({ctl, fl, cnt, adr} !== {5'b00001, to, ab, 32'(k), addr}) begin
      bad++;
      $display("FAIL done d%0d got=%b/%b/%0d/%h exp=00001/%b%b/%0d/%h", d, ctl, fl, cnt, adr, to, ab, k, addr);
    end
  endtask

  task automatic test_reset;
    do_reset;
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #1;
      total++;
      if ({ctl, fl, cnt, adr} !== {5'b01000, 2'b00, 32'd0, 20'd0}) begin
        bad++;
        $display("FAIL reset d%0d got=%b/%b/%0d/%h exp=01000/00/0/0", d, ctl, fl, cnt, adr);
      end
    end
  endtask

  task automatic test_nominal;
    launch_run(0, 20'h00100, 0, 11, 0);
  endtask

  task automatic test_timeout;
    launch_run(0, 20'h12345, 5, 0, 0);
    abort = 1;
    @(negedge clock);
    abort = 0;
    total++;
    if ({ctl, fl, cnt} !== {5'b00001, 2'b10, 32'd5}) begin
      bad++;
      $display("FAIL abort_in_done got=%b/%b/%0d exp=00001/10/5", ctl, fl, cnt);
    end
  endtask

  task automatic test_simultaneous;
    launch_run(0, 20'h00042, 0, 4, 4);
    launch_run(0, 20'h00043, 5, 5, 0);
  endtask

  task automatic test_back_to_back;
    launch_run(0, 20'h55555, 0, 2, 0);
    launch_run(0, 20'h0ABCD, 0, 3, 0);
  endtask

  task automatic test_mid_reset;
    do_reset;
    sel = 0;
    @(negedge clock);
    launch = 1; launch_address = 20'h777; timeout_limit = 0;
    @(negedge clock);
    launch = 0;
    repeat (5) @(negedge clock);
    reset = 0;
    @(negedge clock);
    reset = 1;
    total++;
    if ({ctl, fl, cnt, adr} !== {5'b01000, 2'b00, 32'd0, 20'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b/%0d/%h exp=01000/00/0/0", ctl, fl, cnt, adr);
    end
  endtask

  task automatic test_sweep;
    do_reset;
    launch_run(1, 20'h0BEEF, 0, 2, 0);
    do_reset;
    sel = 1;
    @(negedge clock);
    launch = 1; launch_address = 20'h00321;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      launch = 0;
      abort = i == 6;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      abort = 0;
      total++;
      if ({ctl, fl} !== {5'b01000, 2'b01}) begin
        bad++;
        $display("FAIL start_abort%0d got=%b/%b exp=01000/01", i, ctl, fl);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      int d, h, a;
      logic [31:0] lim;
      d = int'($urandom_range(0, 1));
      lim = 32'($urandom_range(0, 12));
      h = int'($urandom_range(0, 15));
      a = int'($urandom_range(0, 15));
      if (lim == 0 && h == 0 && a == 0) h = int'($urandom_range(1, 15));
      do_reset;
      launch_run(d, 20'($urandom), lim, h, a);
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_timeout;
    test_simultaneous;
    test_back_to_back;
    test_mid_reset;
    test_sweep;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
